localbus_cmd_arbiter: RTL and testbench

Merges LocalBus commands from two independent sources, source A (host/CSR path) and source B (test-script/loopback path), into the single LocalBus command input of the GMII tri-mode Ethernet port top. Each source has its own FIFO. A round-robin arbiter issues at most one 64-bit command per cycle and obeys the port's allmostfull backpressure. Writes that arrive at a full FIFO are dropped and counted per source.

---
 rtl/localbus_cmd_arbiter.sv | 156 +++++++++++++++
 tb/tb_localbus_cmd_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/localbus_cmd_arbiter.sv
// Two-source LocalBus command merger: one FIFO per source, round-robin issue into
// the port, gated by the port's allmostfull, with saturating per-source drop counters.
module localbus_cmd_arbiter #(
    parameter int CMD_W        = 64,
    parameter int FIFO_DEPTH   = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    input  logic             i_cmd_a_wr,
    input  logic [CMD_W-1:0] i_cmd_a,
    output logic             o_cmd_a_allmostfull,
    input  logic             i_cmd_b_wr,
    input  logic [CMD_W-1:0] i_cmd_b,
    output logic             o_cmd_b_allmostfull,
    output logic             o_LocalBus_command_wr,
    output logic [CMD_W-1:0] o_LocalBus_command,
    input  logic             i_LocalBus_allmostfull,
    output logic [15:0]      o_drop_cnt_a,
    output logic [15:0]      o_drop_cnt_b
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_LVL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] THRESH_LVL = (AW+1)'(AFULL_THRESH);
    localparam logic [AW:0] ONE_LVL    = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    logic [CMD_W-1:0] mem_a_q [FIFO_DEPTH];
    logic [CMD_W-1:0] mem_b_q [FIFO_DEPTH];

    logic [AW-1:0]    wr_ptr_a_q, wr_ptr_a_d, rd_ptr_a_q, rd_ptr_a_d;
    logic [AW-1:0]    wr_ptr_b_q, wr_ptr_b_d, rd_ptr_b_q, rd_ptr_b_d;
    logic [AW:0]      level_a_q, level_a_d, level_b_q, level_b_d;
    logic             afull_a_q, afull_a_d, afull_b_q, afull_b_d;
    logic [15:0]      drop_cnt_a_q, drop_cnt_a_d, drop_cnt_b_q, drop_cnt_b_d;
    logic             rr_q, rr_d;
    logic             cmd_wr_q, cmd_wr_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;

    logic empty_a, empty_b, full_a, full_b;
    logic push_a, push_b, drop_a, drop_b;
    logic grant_a, grant_b, permit;

    // Fullness and emptiness come from the registered levels only, so a pop never
    // makes room for a same-cycle write and a fresh write is never issued at once.
    always_comb begin
        empty_a = (level_a_q == '0);
        empty_b = (level_b_q == '0);
        full_a  = (level_a_q == DEPTH_LVL);
        full_b  = (level_b_q == DEPTH_LVL);
        push_a  = i_cmd_a_wr && !full_a;
        push_b  = i_cmd_b_wr && !full_b;
        drop_a  = i_cmd_a_wr && full_a;
        drop_b  = i_cmd_b_wr && full_b;
        permit  = !i_LocalBus_allmostfull;
        grant_a = permit && !empty_a && (empty_b || rr_q == RR_A);
        grant_b = permit && !empty_b && (empty_a || rr_q == RR_B);
    end

    always_comb begin
        wr_ptr_a_d = push_a  ? wr_ptr_a_q + ONE_PTR : wr_ptr_a_q;
        rd_ptr_a_d = grant_a ? rd_ptr_a_q + ONE_PTR : rd_ptr_a_q;
        wr_ptr_b_d = push_b  ? wr_ptr_b_q + ONE_PTR : wr_ptr_b_q;
        rd_ptr_b_d = grant_b ? rd_ptr_b_q + ONE_PTR : rd_ptr_b_q;

        level_a_d = level_a_q;
        case ({push_a, grant_a})
            2'b10:   level_a_d = level_a_q + ONE_LVL;
            2'b01:   level_a_d = level_a_q - ONE_LVL;
            default: level_a_d = level_a_q;
        endcase

        level_b_d = level_b_q;
        case ({push_b, grant_b})
            2'b10:   level_b_d = level_b_q + ONE_LVL;
            2'b01:   level_b_d = level_b_q - ONE_LVL;
            default: level_b_d = level_b_q;
        endcase

        afull_a_d = (level_a_d >= THRESH_LVL);
        afull_b_d = (level_b_d >= THRESH_LVL);

        drop_cnt_a_d = drop_cnt_a_q;
        if (drop_a && drop_cnt_a_q != 16'hFFFF)
            drop_cnt_a_d = drop_cnt_a_q + 16'd1;

        drop_cnt_b_d = drop_cnt_b_q;
        if (drop_b && drop_cnt_b_q != 16'hFFFF)
            drop_cnt_b_d = drop_cnt_b_q + 16'd1;
    end

    // The pointer flips to the other source after any grant and holds otherwise.
    always_comb begin
        rr_d     = rr_q;
        cmd_wr_d = grant_a || grant_b;
        cmd_d    = cmd_q;
        if (grant_a) begin
            rr_d  = RR_B;
            cmd_d = mem_a_q[rd_ptr_a_q];
        end else if (grant_b) begin
            rr_d  = RR_A;
            cmd_d = mem_b_q[rd_ptr_b_q];
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst && push_a)
            mem_a_q[wr_ptr_a_q] <= i_cmd_a;
        if (!i_sys_rst && push_b)
            mem_b_q[wr_ptr_b_q] <= i_cmd_b;
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            wr_ptr_a_q   <= '0;
            rd_ptr_a_q   <= '0;
            wr_ptr_b_q   <= '0;
            rd_ptr_b_q   <= '0;
            level_a_q    <= '0;
            level_b_q    <= '0;
            afull_a_q    <= 1'b0;
            afull_b_q    <= 1'b0;
            drop_cnt_a_q <= '0;
            drop_cnt_b_q <= '0;
            rr_q         <= RR_A;
            cmd_wr_q     <= 1'b0;
            cmd_q        <= '0;
        end else begin
            wr_ptr_a_q   <= wr_ptr_a_d;
            rd_ptr_a_q   <= rd_ptr_a_d;
            wr_ptr_b_q   <= wr_ptr_b_d;
            rd_ptr_b_q   <= rd_ptr_b_d;
            level_a_q    <= level_a_d;
            level_b_q    <= level_b_d;
            afull_a_q    <= afull_a_d;
            afull_b_q    <= afull_b_d;
            drop_cnt_a_q <= drop_cnt_a_d;
            drop_cnt_b_q <= drop_cnt_b_d;
            rr_q         <= rr_d;
            cmd_wr_q     <= cmd_wr_d;
            cmd_q        <= cmd_d;
        end
    end

    assign o_cmd_a_allmostfull   = afull_a_q;
    assign o_cmd_b_allmostfull   = afull_b_q;
    assign o_LocalBus_command_wr = cmd_wr_q;
    assign o_LocalBus_command    = cmd_q;
    assign o_drop_cnt_a          = drop_cnt_a_q;
    assign o_drop_cnt_b          = drop_cnt_b_q;

endmodule

// File: tb/tb_localbus_cmd_arbiter.sv
// Bench for localbus_cmd_arbiter: a per-cycle vector table for the basic paths,
// then hand-written sequences for fill/drop, backpressure and mid-stream reset.
module tb_localbus_cmd_arbiter;

    typedef struct {
        logic        wr_a;
        logic [63:0] cmd_a;
        logic        wr_b;
        logic [63:0] cmd_b;
        logic        port_af;
        logic        exp_wr;
        logic [63:0] exp_cmd;
        logic        exp_af_a;
        logic        exp_af_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_a_wr, cmd_b_wr, port_af;
    logic [63:0] cmd_a, cmd_b;
    logic        af_a, af_b, out_wr;
    logic [63:0] out_cmd;
    logic [15:0] drop_a, drop_b;

    int errors = 0;
    int checks = 0;
    logic [63:0] obs [$];
    vec_t vecs [13];
    int violations;

    localbus_cmd_arbiter #(.CMD_W(64), .FIFO_DEPTH(8), .AFULL_THRESH(6)) dut (
        .i_sys_clk              (clk),
        .i_sys_rst              (rst),
        .i_cmd_a_wr             (cmd_a_wr),
        .i_cmd_a                (cmd_a),
        .o_cmd_a_allmostfull    (af_a),
        .i_cmd_b_wr             (cmd_b_wr),
        .i_cmd_b                (cmd_b),
        .o_cmd_b_allmostfull    (af_b),
        .o_LocalBus_command_wr  (out_wr),
        .o_LocalBus_command     (out_cmd),
        .i_LocalBus_allmostfull (port_af),
        .o_drop_cnt_a           (drop_a),
        .o_drop_cnt_b           (drop_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One clock: the current inputs are sampled at the edge, outputs read 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
        if (out_wr === 1'b1)
            obs.push_back(out_cmd);
    endtask

    task automatic applyStimulus(input vec_t v);
        cmd_a_wr = v.wr_a;
        cmd_a    = v.cmd_a;
        cmd_b_wr = v.wr_b;
        cmd_b    = v.cmd_b;
        port_af  = v.port_af;
        step();
    endtask

    task automatic idleInputs();
        cmd_a_wr = 1'b0;
        cmd_b_wr = 1'b0;
        cmd_a    = '0;
        cmd_b    = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleInputs();
        port_af = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic runVector(input int i);
        applyStimulus(vecs[i]);
        checkOutput($sformatf("vec%0d wr", i), {63'd0, out_wr}, {63'd0, vecs[i].exp_wr});
        checkOutput($sformatf("vec%0d cmd", i), out_cmd, vecs[i].exp_cmd);
        checkOutput($sformatf("vec%0d af_a", i), {63'd0, af_a}, {63'd0, vecs[i].exp_af_a});
        checkOutput($sformatf("vec%0d af_b", i), {63'd0, af_b}, {63'd0, vecs[i].exp_af_b});
    endtask

    function automatic logic [63:0] av(input int i);
        return 64'hA200_0000_0000_0000 + 64'(i);
    endfunction

    function automatic logic [63:0] bv(input int i);
        return 64'hB200_0000_0000_0000 + 64'(i);
    endfunction

    initial begin
        logic [63:0] x1;
        x1 = 64'h1111_0000_0000_0001;

        // Single A write: enters the FIFO at the edge, issued one edge later.
        vecs[0] = '{1'b1, x1, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, x1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, x1, 1'b0, 1'b0};
        // Both sources write four back-to-back after a reset: strict A/B alternation.
        vecs[3]  = '{1'b1, av(0), 1'b1, bv(0), 1'b0, 1'b0, 64'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, av(1), 1'b1, bv(1), 1'b0, 1'b1, av(0), 1'b0, 1'b0};
        vecs[5]  = '{1'b1, av(2), 1'b1, bv(2), 1'b0, 1'b1, bv(0), 1'b0, 1'b0};
        vecs[6]  = '{1'b1, av(3), 1'b1, bv(3), 1'b0, 1'b1, av(1), 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, bv(1), 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, av(2), 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, bv(2), 1'b0, 1'b0};
        vecs[10] = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, av(3), 1'b0, 1'b0};
        vecs[11] = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, bv(3), 1'b0, 1'b0};
        vecs[12] = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, bv(3), 1'b0, 1'b0};

        rst = 1'b1;
        port_af = 1'b0;
        idleInputs();
        doReset();

        checkOutput("reset wr", {63'd0, out_wr}, 64'd0);
        checkOutput("reset cmd", out_cmd, 64'd0);
        checkOutput("reset af_a", {63'd0, af_a}, 64'd0);
        checkOutput("reset af_b", {63'd0, af_b}, 64'd0);
        checkOutput("reset drop_a", {48'd0, drop_a}, 64'd0);
        checkOutput("reset drop_b", {48'd0, drop_b}, 64'd0);

        for (int i = 0; i < 3; i++)
            runVector(i);
        checkOutput("t1 drop_a", {48'd0, drop_a}, 64'd0);
        doReset();
        for (int i = 3; i < 13; i++)
            runVector(i);

        // Fill A with the port stalled: allmostfull at level 6, writes 9 and 10 dropped.
        port_af = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cmd_a_wr = 1'b1;
            cmd_a = 64'hA300_0000_0000_0000 + 64'(i);
            step();
            checkOutput($sformatf("t3 af_a after write %0d", i), {63'd0, af_a}, {63'd0, (i >= 5)});
            checkOutput($sformatf("t3 wr stalled %0d", i), {63'd0, out_wr}, 64'd0);
        end
        idleInputs();
        step();
        checkOutput("t3 drop_a", {48'd0, drop_a}, 64'd2);

        // Full FIFO: a write coinciding with the first pop is still dropped.
        obs.delete();
        port_af = 1'b0;
        cmd_a_wr = 1'b1;
        cmd_a = 64'hDEAD_DEAD_DEAD_DEAD;
        step();
        idleInputs();
        checkOutput("t4 drop_a", {48'd0, drop_a}, 64'd3);
        checkOutput("t4 af_a at level 7", {63'd0, af_a}, 64'd1);
        checkOutput("t4 first pop wr", {63'd0, out_wr}, 64'd1);
        for (int i = 0; i < 12; i++)
            step();
        checkOutput("t3 drained count", 64'(obs.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < obs.size())
                checkOutput($sformatf("t3 order %0d", i), obs[i], 64'hA300_0000_0000_0000 + 64'(i));
        checkOutput("t3 af_a drained", {63'd0, af_a}, 64'd0);

        // B holds six entries; the port toggles allmostfull every cycle.
        port_af = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_b_wr = 1'b1;
            cmd_b = 64'hB500_0000_0000_0000 + 64'(i);
            step();
        end
        idleInputs();
        checkOutput("t5 af_b at level 6", {63'd0, af_b}, 64'd1);
        obs.delete();
        violations = 0;
        for (int c = 0; c < 20; c++) begin
            port_af = c[0];
            step();
            if (out_wr === 1'b1 && c[0] == 1'b1)
                violations++;
        end
        checkOutput("t5 issue while stalled", 64'(violations), 64'd0);
        checkOutput("t5 delivered count", 64'(obs.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < obs.size())
                checkOutput($sformatf("t5 order %0d", i), obs[i], 64'hB500_0000_0000_0000 + 64'(i));
        checkOutput("t5 drop_b", {48'd0, drop_b}, 64'd0);

        // Five entries in each FIFO, start streaming, then reset for one cycle.
        port_af = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_a_wr = 1'b1;
            cmd_a = 64'hA600_0000_0000_0000 + 64'(i);
            cmd_b_wr = 1'b1;
            cmd_b = 64'hB600_0000_0000_0000 + 64'(i);
            step();
        end
        idleInputs();
        checkOutput("t6 af_a at level 5", {63'd0, af_a}, 64'd0);
        checkOutput("t6 af_b at level 5", {63'd0, af_b}, 64'd0);
        obs.delete();
        port_af = 1'b0;
        for (int i = 0; i < 3; i++)
            step();
        checkOutput("t6 streaming count", 64'(obs.size()), 64'd3);
        rst = 1'b1;
        cmd_a_wr = 1'b1;
        cmd_b_wr = 1'b1;
        cmd_a = 64'hEEEE_EEEE_EEEE_EEEE;
        cmd_b = 64'hEEEE_EEEE_EEEE_EEEE;
        step();
        rst = 1'b0;
        idleInputs();
        checkOutput("t6 wr after reset", {63'd0, out_wr}, 64'd0);
        checkOutput("t6 cmd after reset", out_cmd, 64'd0);
        checkOutput("t6 drop_a after reset", {48'd0, drop_a}, 64'd0);
        checkOutput("t6 drop_b after reset", {48'd0, drop_b}, 64'd0);
        obs.delete();
        for (int i = 0; i < 10; i++)
            step();
        checkOutput("t6 stale commands", 64'(obs.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
